// File: rtl/arbiter_rr_hold.sv
// Registered round-robin arbiter with optional multi-cycle grant hold and a hold-length limit.
// Priority rotates past the last winner; all outputs are registered.
module arbiter_rr_hold #(
    parameter int SIZE     = 8,
    parameter int HOLD     = 1,
    parameter int MAX_HOLD = 0,
    localparam int IDX_W   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [SIZE-1:0]  requests,
    input  logic             enable,
    output logic [SIZE-1:0]  grants,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_index
);

    localparam int HCNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  last;
    logic [HCNT_W-1:0] hcnt;

    logic              limit_hit;
    logic              keep;
    logic              found;
    logic [SIZE-1:0]   scan_req;
    logic [IDX_W-1:0]  win;

    logic [SIZE-1:0]   grants_d;
    logic              valid_d;
    logic [IDX_W-1:0]  index_d;
    logic [IDX_W-1:0]  last_d;
    logic [HCNT_W-1:0] hcnt_d;

    assign state = grant_valid ? OWNED : IDLE;

    always_comb begin
        int j;
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        grants_d = grants;
        valid_d  = grant_valid;
        index_d  = grant_index;
        last_d   = last;
        hcnt_d   = hcnt;
        found    = 1'b0;
        win      = last;
        j        = 0;

        limit_hit = (HOLD != 0) && (MAX_HOLD != 0) && (hcnt >= HCNT_W'(MAX_HOLD));
        keep      = (HOLD != 0) && (state == OWNED) && requests[grant_index] && !limit_hit;

        // A holder forced out by the limit is skipped only if someone else is waiting;
        // a sole requester simply wins the scan again with a fresh count.
        scan_req = requests;
        if (limit_hit && (state == OWNED) && |(requests & ~grants))
            scan_req = requests & ~grants;

        for (int k = 1; k <= SIZE; k++) begin
            j = int'(last) + k;
            if (j >= SIZE)
                j = j - SIZE;
            if (!found && scan_req[j]) begin
                found = 1'b1;
                win   = IDX_W'(j);
            end
        end

        if (keep) begin
            if (hcnt != {HCNT_W{1'b1}})
                hcnt_d = hcnt + 1'b1;
        end else if (found) begin
            grants_d = SIZE'(1) << win;
            valid_d  = 1'b1;
            index_d  = win;
            last_d   = win;
            hcnt_d   = HCNT_W'(1);
        end else begin
            grants_d = '0;
            valid_d  = 1'b0;
            hcnt_d   = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grants      <= '0;
            grant_valid <= 1'b0;
            grant_index <= '0;
            last        <= IDX_W'(SIZE - 1);
            hcnt        <= '0;
        end else if (enable) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            grants      <= grants_d;
            grant_valid <= valid_d;
            grant_index <= index_d;
            last        <= last_d;
            hcnt        <= hcnt_d;
        end
    end

endmodule
